// File: rtl/up_counter_pkg.sv
// Shared types and helpers for up_counter: FSM state encoding, default width, terminal-count helper.
package up_counter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int tc_of(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/up_counter.sv
// Modulo-N up counter with IDLE/RUN/DONE start-stop FSM, sync clear/load, tc/wrap/done strobes.
// Build option UP_COUNTER_SATURATE_EN: free-running mode holds at MODULUS-1 instead of wrapping.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(tc_of(MODULUS));

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_at_tc;

  assign w_at_tc = (r_count == TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Priority: clear > load > start/stop > count.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = (load_val > TC) ? TC : load_val;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else if (start) begin
            w_count_nxt = '0;
          end else if (en) begin
            if (!w_at_tc) begin
              w_count_nxt = r_count + WIDTH'(1);
            end else if (oneshot) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
`ifdef UP_COUNTER_SATURATE_EN
              w_count_nxt = r_count;
`else
              w_count_nxt = '0;
              w_wrap_nxt  = 1'b1;
`endif
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    count = r_count;
    tc    = w_at_tc;
    wrap  = r_wrap;
    done  = r_done;
    busy  = (r_state == ST_RUN);
  end

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: MODULUS=32 instance plus a MODULUS=24 instance for load clamping.
module tb_up_counter;

  logic       clk;
  logic       reset;
  logic       start, stop, oneshot, en, clear, load;
  logic [4:0] load_val;
  logic [4:0] a_count, b_count;
  logic       a_tc, a_wrap, a_done, a_busy;
  logic       b_tc, b_wrap, b_done, b_busy;

  int n_cmp = 0;
  int n_err = 0;

  up_counter #(.WIDTH(5), .MODULUS(32)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
    .en(en), .clear(clear), .load(load), .load_val(load_val),
    .count(a_count), .tc(a_tc), .wrap(a_wrap), .done(a_done), .busy(a_busy)
  );

  up_counter #(.WIDTH(5), .MODULUS(24)) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
    .en(en), .clear(clear), .load(load), .load_val(load_val),
    .count(b_count), .tc(b_tc), .wrap(b_wrap), .done(b_done), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    #7;
    check("rst_count", 32'(a_count), 0);
    check("rst_wrap",  32'(a_wrap), 0);
    check("rst_done",  32'(a_done), 0);
    check("rst_busy",  32'(a_busy), 0);
    #5 reset = 1'b1;
    step();
    check("idle_after_rst", 32'(a_count), 0);

    // Free-running count 0..31 then wrap
    start = 1'b1; en = 1'b1; oneshot = 1'b0;
    step();
    start = 1'b0;
    check("run_start_count", 32'(a_count), 0);
    check("run_start_busy",  32'(a_busy), 1);
    for (int i = 1; i <= 31; i++) begin
      step();
      check("run_count", 32'(a_count), 32'(i));
      check("run_tc",    32'(a_tc), (i == 31) ? 1 : 0);
      check("run_wrap",  32'(a_wrap), 0);
    end
    step();
`ifdef UP_COUNTER_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      check("sat_count", 32'(a_count), 31);
      check("sat_wrap",  32'(a_wrap), 0);
      check("sat_busy",  32'(a_busy), 1);
      step();
    end
`else
    check("wrap_count", 32'(a_count), 0);
    check("wrap_pulse", 32'(a_wrap), 1);
    check("wrap_tc",    32'(a_tc), 0);
    step();
    check("wrap_next_count", 32'(a_count), 1);
    check("wrap_next_pulse", 32'(a_wrap), 0);
`endif

    // One-shot run
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 32'(a_busy), 0);
    oneshot = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("os_start", 32'(a_count), 0);
    for (int i = 0; i < 31; i++) step();
    check("os_at_tc",   32'(a_count), 31);
    check("os_busy_tc", 32'(a_busy), 1);
    check("os_done_pre", 32'(a_done), 0);
    step();
    check("os_done",       32'(a_done), 1);
    check("os_done_busy",  32'(a_busy), 0);
    check("os_done_count", 32'(a_count), 31);
    step();
    check("os_idle_done",  32'(a_done), 0);
    check("os_idle_busy",  32'(a_busy), 0);
    check("os_idle_count", 32'(a_count), 31);
    step();
    check("os_hold_count", 32'(a_count), 31);
    check("os_hold_done",  32'(a_done), 0);

    // Enable gating and stop
    oneshot = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("en_at7", 32'(a_count), 7);
    en = 1'b1; step(); check("en_1", 32'(a_count), 8);
    en = 1'b0; step(); check("en_0", 32'(a_count), 8);
    en = 1'b1; step(); check("en_1b", 32'(a_count), 9);
    stop = 1'b1; step();
    stop = 1'b0;
    check("stop_count", 32'(a_count), 9);
    check("stop_idle",  32'(a_busy), 0);
    step();
    check("idle_en_ignored", 32'(a_count), 9);

    // Clear beats load; load clamps to MODULUS-1
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_clear", 32'(a_count), 5);
    load = 1'b1; load_val = 5'd20; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_wins", 32'(a_count), 0);
    check("clear_busy", 32'(a_busy), 0);
    load_val = 5'd31;
    step();
    load = 1'b0;
    check("load_a",    32'(a_count), 31);
    check("load_clamp", 32'(b_count), 23);
    check("load_b_tc", 32'(b_tc), 1);
    check("load_b_wrap", 32'(b_wrap), 0);

    // Asynchronous reset mid-run
    en = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("pre_reset", 32'(a_count), 12);
    reset = 1'b0;
    #1;
    check("areset_count", 32'(a_count), 0);
    check("areset_wrap",  32'(a_wrap), 0);
    check("areset_done",  32'(a_done), 0);
    check("areset_busy",  32'(a_busy), 0);
    #1 reset = 1'b1;
    step();
    check("post_reset_count", 32'(a_count), 0);
    check("post_reset_busy",  32'(a_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
